mcif_axi_rd_rsp: RTL
====================

Name: mcif_axi_rd_rsp

Overview:
- AXI4 read responder (slave side) of the MCIF read path.
- Accepts AR commands from an `mcif_rd_*` read master, queues them, and returns R bursts from an internal word-addressed memory.
- Used as the DDR stand-in for block-level and MCIF integration simulation, and as an on-chip read-only buffer.
- Commands are serviced strictly in order; RID echoes ARID.

Parameters:
- ID_WIDTH, 4, AXI ID width.
- DATA_WIDTH, 256, RDATA width in bits; equals MAX_DAT_DW*Tout.
- LEN_WIDTH, 8, ARLEN width; equals log2AXI_BURST_LEN.
- MEM_WORDS, 1024, memory depth in DATA_WIDTH words.
- CMD_DEPTH, 4, AR command FIFO depth; must be a power of 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- S_AXI_ARID  in  ID_WIDTH  read ID
- S_AXI_ARADDR  in  32  byte address
- S_AXI_ARLEN  in  LEN_WIDTH  beats-1
- S_AXI_ARBURST  in  2  00=FIXED, otherwise INCR
- S_AXI_ARVALID  in  1  AR valid
- S_AXI_ARREADY  out  1  AR ready
- S_AXI_RID  out  ID_WIDTH  echoed ID
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_RLAST  out  1  last beat
- S_AXI_RVALID  out  1  R valid
- S_AXI_RREADY  in  1  R ready
- ld_en  in  1  backdoor memory write enable
- ld_addr  in  log2(MEM_WORDS)  backdoor word address
- ld_data  in  DATA_WIDTH  backdoor write data
- busy  out  1  FIFO non-empty or burst in progress

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied, FSM to IDLE.
  - RVALID, RLAST, RID, RDATA, RRESP all 0; busy 0.
  - ARREADY=1 from the first cycle after reset.
  - Memory contents are not reset.
  - Reset mid-burst discards the remaining beats and all queued commands with no further R output.
- AR channel:
  - ARREADY = !fifo_full, combinational.
  - Handshake = ARVALID & ARREADY; pushes {ID, ADDR, LEN, BURST}.
  - At full, ARREADY=0 and ARVALID is held off by the master; no command is dropped.
- Word index = ARADDR >> log2(DATA_WIDTH/8). Low address bits are ignored; no unaligned support.
- FSM:
  - IDLE: if FIFO non-empty, pop the head; load addr_cnt=index, beat_cnt=0, len, id, fixed flag; go to BURST.
  - BURST: when (!RVALID | RREADY), load the R output registers:
    - RDATA = mem[addr_cnt], or 0 if addr_cnt>=MEM_WORDS;
    - RRESP = 00, or 10 if addr_cnt>=MEM_WORDS;
    - RID = id; RLAST = (beat_cnt==len); RVALID = 1.
    - Then beat_cnt++; addr_cnt++ unless fixed.
  - After the RLAST beat is loaded:
    - if FIFO non-empty, pop the next command in the same cycle and stay in BURST (back-to-back, no bubble);
    - else go to IDLE.
- R registers:
  - If RVALID & RREADY and no new beat is loaded, RVALID<=0 next cycle.
  - While RVALID & !RREADY, all R outputs are held stable.
- Latency: with FIFO empty and FSM in IDLE, AR handshake in cycle T gives first RVALID in cycle T+3. Sustained throughput is 1 beat/cycle with RREADY=1.
- Address arithmetic:
  - addr_cnt is 32-bit with no 4KB boundary check.
  - An INCR burst crossing MEM_WORDS returns OKAY beats below the limit and SLVERR beats (data 0) at or above it; no wrap-around.
- ARLEN=0 gives a single beat with RLAST=1.
- Backdoor write:
  - mem[ld_addr]<=ld_data at posedge.
  - A beat read of the same word in the same cycle returns the old data.
  - ld_en while busy is legal.
- Simultaneous FIFO push and pop at full is impossible because ARREADY=0. At non-full, push and pop in the same cycle keep the count unchanged.
- busy = fifo_count!=0 | FSM!=IDLE | RVALID.

Test Plan:
- Reset: assert rst 2 cycles with ARVALID=1 -> no push; afterwards ARREADY=1, RVALID=0, RDATA=0.
- Single beat: preload mem[5]=X; AR{ID=3, ADDR=5*32, LEN=0, INCR} at T, RREADY=1 -> RVALID at T+3, RDATA=X, RID=3, RLAST=1, RRESP=00, RVALID=0 at T+4.
- INCR burst with backpressure: AR{ID=1, ADDR=0, LEN=7}, RREADY toggling 1010... -> 8 beats mem[0..7] in order, outputs stable while stalled, RLAST only on beat 8.
- FIFO full and back-to-back: RREADY=0, issue 6 ARs of LEN=3 IDs 0-5 -> first 5 accepted (4 in FIFO + 1 popped), ARREADY=0 until the R stall is released; then all 24 beats contiguous, IDs in order 0..5.
- Out-of-range and FIXED: AR{ADDR=(MEM_WORDS-2)*32, LEN=3, INCR} -> beats 1-2 OKAY with data, beats 3-4 SLVERR with data 0. AR{ADDR=10*32, LEN=2, FIXED} -> mem[10] three times.
- Reset mid-burst: LEN=15 burst, assert rst after beat 4 with 2 commands queued -> RVALID=0 next cycle, no further beats, busy=0; a fresh AR afterwards responds normally.

Source files
------------

// File: rtl/mcif_axi_rd_rsp_if.sv
// AXI4 read-channel bundle (AR + R) between an MCIF read master and a read responder.
interface mcif_axi_rd_rsp_if #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned LEN_WIDTH  = 8
);
    logic [ID_WIDTH-1:0]   S_AXI_ARID;
    logic [31:0]           S_AXI_ARADDR;
    logic [LEN_WIDTH-1:0]  S_AXI_ARLEN;
    logic [1:0]            S_AXI_ARBURST;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [ID_WIDTH-1:0]   S_AXI_RID;
    logic [DATA_WIDTH-1:0] S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RLAST;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport master (
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );
endinterface

// File: rtl/mcif_axi_rd_rsp.sv
// AXI4 read responder: queues AR commands in order and returns R bursts from an internal
// word-addressed memory that is filled through a backdoor write port.
module mcif_axi_rd_rsp #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned CMD_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    mcif_axi_rd_rsp_if.slave             axi,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]        ld_data,
    output logic                         busy
);
    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned PW    = $clog2(CMD_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 8);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    // Command FIFO
    logic [ID_WIDTH-1:0]  fifo_id    [CMD_DEPTH];
    logic [31:0]          fifo_addr  [CMD_DEPTH];
    logic [LEN_WIDTH-1:0] fifo_len   [CMD_DEPTH];
    logic                 fifo_fixed [CMD_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 fifo_full, fifo_empty, push, pop;

    // Burst state
    state_e               state_q, state_d;
    logic [31:0]          addr_cnt_q, addr_cnt_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic                 fixed_q, fixed_d;
    logic                 load_beat;

    // R output registers
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q, rvalid_q;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  in_range;

    assign fifo_full  = (count_q == CW'(CMD_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = axi.S_AXI_ARVALID & ~fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr_q]    <= axi.S_AXI_ARID;
            fifo_addr[wr_ptr_q]  <= axi.S_AXI_ARADDR;
            fifo_len[wr_ptr_q]   <= axi.S_AXI_ARLEN;
            fifo_fixed[wr_ptr_q] <= (axi.S_AXI_ARBURST == 2'b00);
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        load_beat  = 1'b0;
        addr_cnt_d = addr_cnt_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        id_d       = id_q;
        fixed_d    = fixed_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (!rvalid_q || axi.S_AXI_RREADY) begin
                    load_beat = 1'b1;
                    if (beat_cnt_q == len_q) begin
                        // Chain straight into the next queued command to avoid a bubble
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (!fixed_q) addr_cnt_d = addr_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            addr_cnt_d = fifo_addr[rd_ptr_q] >> SHIFT;
            beat_cnt_d = '0;
            len_d      = fifo_len[rd_ptr_q];
            id_d       = fifo_id[rd_ptr_q];
            fixed_d    = fifo_fixed[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_cnt_q <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            id_q       <= '0;
            fixed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            id_q       <= id_d;
            fixed_q    <= fixed_d;
        end
    end

    // Backdoor load; a same-cycle beat read sees the pre-write word
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    assign in_range = (addr_cnt_q < 32'(MEM_WORDS));
    assign rd_word  = mem[addr_cnt_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else if (load_beat) begin
            rid_q    <= id_q;
            rdata_q  <= in_range ? rd_word : '0;
            rresp_q  <= in_range ? 2'b00 : 2'b10;
            rlast_q  <= (beat_cnt_q == len_q);
            rvalid_q <= 1'b1;
        end else if (rvalid_q && axi.S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign axi.S_AXI_ARREADY = ~fifo_full;
    assign axi.S_AXI_RID     = rid_q;
    assign axi.S_AXI_RDATA   = rdata_q;
    assign axi.S_AXI_RRESP   = rresp_q;
    assign axi.S_AXI_RLAST   = rlast_q;
    assign axi.S_AXI_RVALID  = rvalid_q;

    assign busy = (count_q != '0) | (state_q != StIdle) | rvalid_q;
endmodule
